// File: rtl/ringbuffer_level.sv
// Pointer and flag controller for the capture ring buffer. It sits between
// the LPC frame decoder (writer) and the host readout (reader), and it
// provides write and read addresses for an external dual-port RAM.
// The write and read pointers are one bit wider than the address. Their
// difference gives the fill level, and the extra bit tells full apart from
// empty without a separate counter.
module ringbuffer_level #(
  parameter int BITS         = 7,
  parameter int AFULL_THRESH = (2**BITS) - 8,
  parameter bit OVERWRITE    = 1'b0,
  parameter int DROP_BITS    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_done,
  input  logic                 read_done,
  input  logic                 clear_flags,
  output logic [BITS-1:0]      write_addr,
  output logic [BITS-1:0]      read_addr,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic [BITS:0]        level,
  output logic                 overflow,
  output logic                 underflow,
  output logic [DROP_BITS-1:0] drop_count
);

  localparam logic [BITS:0]      PTR_ONE  = {{BITS{1'b0}}, 1'b1};
  localparam logic [DROP_BITS-1:0] DROP_ONE = {{(DROP_BITS-1){1'b0}}, 1'b1};
  localparam logic [BITS:0]      AFULL_LV = (BITS+1)'(AFULL_THRESH);

  logic [BITS:0]          r_wp;
  logic [BITS:0]          r_rp;
  logic                   r_overflow;
  logic                   r_underflow;
  logic [DROP_BITS-1:0]   r_drop_count;

  logic [BITS:0]          w_level;
  logic                   w_empty;
  logic                   w_full;
  logic [BITS:0]          w_wp_next;
  logic [BITS:0]          w_rp_next;
  logic                   w_drop;
  logic                   w_underrun;
  logic                   w_ovf_base;
  logic                   w_unf_base;
  logic [DROP_BITS-1:0]   w_dc_base;
  logic                   w_ovf_next;
  logic                   w_unf_next;
  logic [DROP_BITS-1:0]   w_dc_next;

  // Fill level and status flags, decoded from the registered pointers.
  always_comb begin
    w_level = r_wp - r_rp;
    w_empty = (w_level == '0);
    w_full  = w_level[BITS];
  end

  // Pointer movement for this edge, based on the strobes and the current level.
  always_comb begin
    w_wp_next  = r_wp;
    w_rp_next  = r_rp;
    w_drop     = 1'b0;
    w_underrun = 1'b0;
    unique case ({write_done, read_done})
      2'b10: begin
        if (!w_full) begin
          w_wp_next = r_wp + PTR_ONE;
        end else begin
          w_drop = 1'b1;
          if (OVERWRITE) begin
            // Discard the oldest entry so the new one fits. The level stays at capacity.
            w_wp_next = r_wp + PTR_ONE;
            w_rp_next = r_rp + PTR_ONE;
          end
        end
      end
      2'b01: begin
        if (!w_empty) begin
          w_rp_next = r_rp + PTR_ONE;
        end else begin
          w_underrun = 1'b1;
        end
      end
      2'b11: begin
        // A simultaneous read on an empty buffer has nothing to consume.
        // The write still lands.
        w_wp_next = r_wp + PTR_ONE;
        if (w_empty) begin
          w_underrun = 1'b1;
        end else begin
          w_rp_next = r_rp + PTR_ONE;
        end
      end
      default: ;
    endcase
  end

  // Sticky flags and the drop counter. clear_flags takes effect first, so an
  // event in the same cycle is still recorded.
  always_comb begin
    w_ovf_base = clear_flags ? 1'b0 : r_overflow;
    w_unf_base = clear_flags ? 1'b0 : r_underflow;
    w_dc_base  = clear_flags ? '0   : r_drop_count;
    w_ovf_next = w_ovf_base | w_drop;
    w_unf_next = w_unf_base | w_underrun;
    w_dc_next  = w_dc_base;
    if (w_drop && !(&w_dc_base)) begin
      w_dc_next = w_dc_base + DROP_ONE;
    end
  end

  // State registers. A synchronous active-low reset takes priority over any strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp         <= '0;
      r_rp         <= '0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_wp         <= w_wp_next;
      r_rp         <= w_rp_next;
      r_overflow   <= w_ovf_next;
      r_underflow  <= w_unf_next;
      r_drop_count <= w_dc_next;
    end
  end

  // Outputs, all taken directly from registers or decoded from them.
  always_comb begin
    write_addr  = r_wp[BITS-1:0];
    read_addr   = r_rp[BITS-1:0];
    level       = w_level;
    empty       = w_empty;
    full        = w_full;
    almost_full = (w_level >= AFULL_LV);
    overflow    = r_overflow;
    underflow   = r_underflow;
    drop_count  = r_drop_count;
  end

endmodule

// File: tb/tb_ringbuffer_level.sv
// Bench for ringbuffer_level. Two instances, one dropping new data and one
// overwriting the oldest, share the same stimulus. Each is compared against
// an entry-count model.
module tb_ringbuffer_level;

  localparam int BITS = 7;
  localparam int DB   = 16;
  localparam int CAP  = 2**BITS;
  localparam int AF   = CAP - 8;
  localparam int DMAX = 2**DB - 1;

  logic clk = 1'b0;
  logic reset = 1'b0, write_done = 1'b0, read_done = 1'b0, clear_flags = 1'b0;

  logic [BITS-1:0] wa [2];
  logic [BITS-1:0] ra [2];
  logic [BITS:0]   lvl [2];
  logic            emp [2], ful [2], afl [2], ovf [2], unf [2];
  logic [DB-1:0]   dc [2];

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: entry count and slot indices, per instance.
  int m_lvl [2], m_wa [2], m_ra [2], m_ovf [2], m_unf [2], m_dc [2];

  always #5 clk = ~clk;

  ringbuffer_level #(.BITS(BITS), .AFULL_THRESH(AF), .OVERWRITE(1'b0), .DROP_BITS(DB)) u_dut0 (
    .clk(clk), .reset(reset), .write_done(write_done), .read_done(read_done),
    .clear_flags(clear_flags), .write_addr(wa[0]), .read_addr(ra[0]), .empty(emp[0]),
    .full(ful[0]), .almost_full(afl[0]), .level(lvl[0]), .overflow(ovf[0]),
    .underflow(unf[0]), .drop_count(dc[0]));

  ringbuffer_level #(.BITS(BITS), .AFULL_THRESH(AF), .OVERWRITE(1'b1), .DROP_BITS(DB)) u_dut1 (
    .clk(clk), .reset(reset), .write_done(write_done), .read_done(read_done),
    .clear_flags(clear_flags), .write_addr(wa[1]), .read_addr(ra[1]), .empty(emp[1]),
    .full(ful[1]), .almost_full(afl[1]), .level(lvl[1]), .overflow(ovf[1]),
    .underflow(unf[1]), .drop_count(dc[1]));

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one edge using the strobes currently driven.
  function automatic void model_step();
    for (int m = 0; m < 2; m++) begin
      if (!reset) begin
        m_lvl[m] = 0; m_wa[m] = 0; m_ra[m] = 0;
        m_ovf[m] = 0; m_unf[m] = 0; m_dc[m] = 0;
      end else begin
        if (clear_flags) begin
          m_ovf[m] = 0; m_unf[m] = 0; m_dc[m] = 0;
        end
        if (write_done && read_done) begin
          m_wa[m] = (m_wa[m] + 1) % CAP;
          if (m_lvl[m] == 0) begin
            m_lvl[m] = 1;
            m_unf[m] = 1;
          end else begin
            m_ra[m] = (m_ra[m] + 1) % CAP;
          end
        end else if (write_done) begin
          if (m_lvl[m] < CAP) begin
            m_wa[m] = (m_wa[m] + 1) % CAP;
            m_lvl[m]++;
          end else begin
            m_ovf[m] = 1;
            if (m_dc[m] < DMAX) m_dc[m]++;
            if (m == 1) begin
              m_wa[m] = (m_wa[m] + 1) % CAP;
              m_ra[m] = (m_ra[m] + 1) % CAP;
            end
          end
        end else if (read_done) begin
          if (m_lvl[m] > 0) begin
            m_ra[m] = (m_ra[m] + 1) % CAP;
            m_lvl[m]--;
          end else begin
            m_unf[m] = 1;
          end
        end
      end
    end
  endfunction

  task automatic check_model();
    for (int m = 0; m < 2; m++) begin
      cmp($sformatf("d%0d.level", m), int'(lvl[m]), m_lvl[m]);
      cmp($sformatf("d%0d.write_addr", m), int'(wa[m]), m_wa[m]);
      cmp($sformatf("d%0d.read_addr", m), int'(ra[m]), m_ra[m]);
      cmp($sformatf("d%0d.empty", m), int'(emp[m]), int'(m_lvl[m] == 0));
      cmp($sformatf("d%0d.full", m), int'(ful[m]), int'(m_lvl[m] == CAP));
      cmp($sformatf("d%0d.almost_full", m), int'(afl[m]), int'(m_lvl[m] >= AF));
      cmp($sformatf("d%0d.overflow", m), int'(ovf[m]), m_ovf[m]);
      cmp($sformatf("d%0d.underflow", m), int'(unf[m]), m_unf[m]);
      cmp($sformatf("d%0d.drop_count", m), int'(dc[m]), m_dc[m]);
    end
  endtask

  task automatic step(input logic rst, input logic w, input logic r, input logic c);
    reset = rst; write_done = w; read_done = r; clear_flags = c;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  typedef struct {
    logic rst, w, r, c;
    int   lvl, wa, ra, e, f, o, u;
  } vec_t;

  vec_t tbl [12];

  initial begin
    // Expected values for the drop-mode instance, starting from reset.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 2, 0, 0, 0, 0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 2, 1, 0, 0, 0, 0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 3, 2, 0, 0, 0, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 3, 3, 1, 0, 0, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 3, 3, 1, 0, 0, 1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 4, 3, 0, 0, 0, 1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 4, 3, 0, 0, 0, 0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 4, 4, 1, 0, 0, 0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 4, 4, 1, 0, 0, 1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1, 0, 0, 0};

    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].w, tbl[i].r, tbl[i].c);
      cmp($sformatf("tbl%0d.level", i), int'(lvl[0]), tbl[i].lvl);
      cmp($sformatf("tbl%0d.write_addr", i), int'(wa[0]), tbl[i].wa);
      cmp($sformatf("tbl%0d.read_addr", i), int'(ra[0]), tbl[i].ra);
      cmp($sformatf("tbl%0d.empty", i), int'(emp[0]), tbl[i].e);
      cmp($sformatf("tbl%0d.full", i), int'(ful[0]), tbl[i].f);
      cmp($sformatf("tbl%0d.overflow", i), int'(ovf[0]), tbl[i].o);
      cmp($sformatf("tbl%0d.underflow", i), int'(unf[0]), tbl[i].u);
    end

    // Fill to capacity and check almost_full at its threshold.
    for (int i = 1; i <= CAP; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (i == AF - 1) cmp("afull_below", int'(afl[0]), 0);
      if (i == AF)     cmp("afull_at", int'(afl[0]), 1);
    end
    cmp("fill.write_addr", int'(wa[0]), 0);
    cmp("fill.level", int'(lvl[0]), CAP);
    cmp("fill.full", int'(ful[0]), 1);

    // Write while full: drop mode vs overwrite mode.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    cmp("ovf0.write_addr", int'(wa[0]), 0);
    cmp("ovf0.read_addr", int'(ra[0]), 0);
    cmp("ovf0.overflow", int'(ovf[0]), 1);
    cmp("ovf0.drop_count", int'(dc[0]), 1);
    cmp("ovf1.write_addr", int'(wa[1]), 1);
    cmp("ovf1.read_addr", int'(ra[1]), 1);
    cmp("ovf1.level", int'(lvl[1]), CAP);
    cmp("ovf1.drop_count", int'(dc[1]), 1);

    step(1'b1, 1'b0, 1'b0, 1'b1);
    cmp("clr.overflow", int'(ovf[0]), 0);
    cmp("clr.drop_count", int'(dc[0]), 0);

    step(1'b1, 1'b0, 1'b1, 1'b0);
    cmp("rd.read_addr", int'(ra[0]), 1);
    cmp("rd.full", int'(ful[0]), 0);

    // Refill, then a simultaneous write and read at full: no drop.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    cmp("wr_full.level", int'(lvl[0]), CAP);
    cmp("wr_full.drop_count", int'(dc[0]), 0);
    cmp("wr_full.write_addr", int'(wa[0]), 2);
    cmp("wr_full.read_addr", int'(ra[0]), 2);

    // Reset partway through filling.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    cmp("wr5.level", int'(lvl[0]), 5);
    cmp("wr5.write_addr", int'(wa[0]), 6);
    cmp("wr5.read_addr", int'(ra[0]), 1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    cmp("midrst.level", int'(lvl[0]), 0);
    cmp("midrst.write_addr", int'(wa[0]), 0);

    // Random traffic, alternating between write-heavy and read-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      int wp;
      logic rr, ww, xr, cc;
      wp = ((i / 250) % 2 == 0) ? 80 : 25;
      ww = ($urandom_range(99) < wp);
      xr = ($urandom_range(99) < (100 - wp));
      cc = ($urandom_range(19) == 0);
      rr = ($urandom_range(399) != 0);
      step(rr, ww, xr, cc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
